// File: rtl/poly_eval.sv
// rtl/poly_eval.sv - Horner-rule polynomial evaluator, one multiply or add per cycle
//
// Evaluates P(x) = c_DEGREE*x^DEGREE + ... + c_1*x + c_0 from a coefficient
// stream (highest degree first). All arithmetic is W-bit two's-complement
// wrap; a sticky flag records any intermediate that did not fit.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   start       in   begin an evaluation (honoured in IDLE only)
//   valor_x     in   XW-bit signed x, sampled with start
//   coef        in   W-bit signed coefficient
//   coef_valid  in   coef holds a coefficient
//   coef_ready  out  coefficient is accepted this cycle (FETCH)
//   busy        out  evaluation in progress (not IDLE)
//   done        out  one-cycle pulse, resultado/overflow just updated
//   resultado   out  W-bit signed result of the last completed evaluation
//   overflow    out  an intermediate of the last evaluation overflowed W bits
module poly_eval #(
  parameter int XW     = 8,
  parameter int W      = 16,
  parameter int DEGREE = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [XW-1:0] valor_x,
  input  logic [W-1:0] coef,
  input  logic         coef_valid,
  output logic         coef_ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] resultado,
  output logic         overflow
);

  localparam int RW = $clog2(DEGREE + 2);

  typedef enum logic [1:0] {IDLE, FETCH, MUL, DONE} state_e;

  state_e                state_q, state_d;
  logic signed [W-1:0]   acc_q, acc_d;
  logic signed [W-1:0]   x_q, x_d;
  logic signed [W-1:0]   res_q, res_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic                  ovf_q, ovf_d;

  logic [W:0]            sum;
  logic signed [2*W-1:0] prod;
  logic                  add_ovf;
  logic                  mul_ovf;

  // One extra bit on the add exposes signed overflow as a carry/sign disagreement.
  assign sum     = {acc_q[W-1], acc_q} + {coef[W-1], coef};
  assign add_ovf = sum[W] ^ sum[W-1];

  // Full-precision product; it fits W signed bits only if the top W+1 bits agree.
  assign prod    = (2*W)'(acc_q) * (2*W)'(x_q);
  assign mul_ovf = prod[2*W-1:W-1] != {(W+1){prod[W-1]}};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_d       = x_q;
    rem_d     = rem_q;
    ovf_acc_d = ovf_acc_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d       = W'($signed(valor_x));
          rem_d     = RW'(DEGREE + 1);
          ovf_acc_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (coef_valid) begin
          // rem still at its start value marks the leading coefficient.
          if (rem_q == RW'(DEGREE + 1)) begin
            acc_d = coef;
          end else begin
            acc_d     = sum[W-1:0];
            ovf_acc_d = ovf_acc_q | add_ovf;
          end
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) begin
            // Publish on entry to DONE so the outputs are valid alongside the pulse.
            res_d   = acc_d;
            ovf_d   = ovf_acc_d;
            state_d = DONE;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d     = prod[W-1:0];
        ovf_acc_d = ovf_acc_q | mul_ovf;
        state_d   = FETCH;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      x_q       <= '0;
      rem_q     <= '0;
      ovf_acc_q <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      rem_q     <= rem_d;
      ovf_acc_q <= ovf_acc_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
    end
  end

  assign coef_ready = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign resultado  = res_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_poly_eval.sv
// tb/tb_poly_eval.sv - self-checking bench for poly_eval against an integer reference model
module tb_poly_eval;

  localparam int XW     = 8;
  localparam int W      = 16;
  localparam int DEGREE = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [XW-1:0] valor_x;
  logic [W-1:0]  coef;
  logic          coef_valid;
  logic          coef_ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  resultado;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cur_c [0:DEGREE];

  poly_eval #(.XW(XW), .W(W), .DEGREE(DEGREE)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .valor_x    (valor_x),
    .coef       (coef),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done),
    .resultado  (resultado),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrapw(input longint v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return longint'($signed(t));
  endfunction

  // Exact integer arithmetic; any intermediate outside the W-bit signed range
  // sets the flag, and the running value is then reduced modulo 2^W.
  function automatic void model(input int x, output int res, output bit ovf);
    longint a, lo, hi;
    lo  = -(longint'(1) << (W - 1));
    hi  = -lo - 1;
    ovf = 1'b0;
    a   = cur_c[DEGREE];
    for (int i = DEGREE - 1; i >= 0; i--) begin
      a = a * x;
      if (a < lo || a > hi) ovf = 1'b1;
      a = wrapw(a);
      a = a + cur_c[i];
      if (a < lo || a > hi) ovf = 1'b1;
      a = wrapw(a);
    end
    res = int'(a);
  endfunction

  task automatic run_eval(input int x, input int stall_idx, input int stalls, input bit noise, input string tag);
    int k, cyc, left, exp_res, seen_cyc;
    bit exp_ovf;
    bit seen;
    model(x, exp_res, exp_ovf);
    start      = 1'b1;
    valor_x    = XW'(x);
    coef_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0; left = stalls; cyc = 0; seen = 1'b0; seen_cyc = -1;
    while (!seen && cyc < 200) begin
      if (coef_ready && k <= DEGREE) begin
        if (k == stall_idx && left > 0) begin
          coef_valid = 1'b0;
          coef       = W'($urandom);
          left--;
        end else begin
          coef_valid = 1'b1;
          coef       = W'(cur_c[DEGREE - k]);
          k++;
        end
      end else begin
        coef_valid = noise ? 1'($urandom) : 1'b1;
        coef       = W'($urandom);
      end
      start = noise ? 1'($urandom) : 1'b0;
      @(posedge clock); cyc++; #1;
      if (done) begin
        seen     = 1'b1;
        seen_cyc = cyc + 1;
      end
    end
    chk({tag, "_latency"}, seen_cyc, 2 * DEGREE + 2 + stalls);
    chk({tag, "_res"}, $signed(resultado), exp_res);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_busy_in_done"}, busy, 1);
    // A start presented during DONE must not launch a new run.
    start      = noise;
    coef_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_after"}, busy, 0);
    chk({tag, "_res_hold"}, $signed(resultado), exp_res);
  endtask

  initial begin
    int nd;
    reset = 1'b1; start = 1'b0; valor_x = '0; coef = '0; coef_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", coef_ready, 0);
    chk("rst_res", $signed(resultado), 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    cur_c[2] = 2; cur_c[1] = -5; cur_c[0] = 7;
    run_eval(3, 0, 0, 1'b0, "basic");
    chk("basic_const", $signed(resultado), 10);

    cur_c[2] = 1; cur_c[1] = 1; cur_c[0] = 1;
    run_eval(-1, 0, 0, 1'b0, "xneg1");
    chk("xneg1_const", $signed(resultado), 1);

    cur_c[2] = 0; cur_c[1] = 1; cur_c[0] = 0;
    run_eval(-128, 0, 0, 1'b0, "xmin");
    chk("xmin_const", $signed(resultado), -128);

    cur_c[2] = 4; cur_c[1] = 0; cur_c[0] = 0;
    run_eval(100, 0, 0, 1'b0, "wrap");
    chk("wrap_const", $signed(resultado), -25536);
    chk("wrap_ovf_const", overflow, 1);

    cur_c[2] = 0; cur_c[1] = 0; cur_c[0] = 5;
    run_eval(1, 0, 0, 1'b0, "ovf_clear");
    chk("ovf_clear_const", overflow, 0);

    cur_c[2] = 1; cur_c[1] = 1; cur_c[0] = 1;
    run_eval(2, 1, 3, 1'b0, "stall");
    chk("stall_const", $signed(resultado), 7);

    cur_c[2] = -3; cur_c[1] = 6; cur_c[0] = -2;
    run_eval(5, 2, 2, 1'b1, "start_noise");

    // Abort during MUL: reset wins, no done, outputs cleared.
    cur_c[2] = 9; cur_c[1] = 9; cur_c[0] = 9;
    start = 1'b1; valor_x = XW'(4);
    @(posedge clock); #1;
    start = 1'b0; coef_valid = 1'b1; coef = W'(9);
    @(posedge clock); #1;
    chk("abort_in_mul", {busy, coef_ready}, 2'b10);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; coef_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_res", $signed(resultado), 0);
    chk("abort_done", done, 0);
    nd = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_eval(4, 0, 0, 1'b0, "after_abort");

    for (int r = 0; r < 24; r++) begin
      logic [XW-1:0] rx;
      logic [W-1:0]  rc;
      rx = XW'($urandom);
      for (int i = 0; i <= DEGREE; i++) begin
        rc = W'($urandom);
        cur_c[i] = (r % 2 == 0) ? int'($urandom_range(0, 15)) - 8 : int'($signed(rc));
      end
      run_eval(int'($signed(rx)), int'($urandom_range(0, DEGREE)), int'($urandom_range(0, 3)),
               1'($urandom), $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
